// File: rtl/rvga_mem_responder_pkg.sv
// Shared types for the RVGA memory responder: FSM state encoding, word type,
// the out-of-range error word and the address range helper.
package rvga_types;

  typedef logic [31:0] rvga_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IMEM = 2'd1,
    DMEM = 2'd2
  } rvga_mem_state;

  localparam rvga_word RVGA_MEM_ERR_WORD = 32'hDEADBEEF;

  // True when any byte-address bit above the word-index field is set.
  function automatic logic rvga_addr_oob(input rvga_word addr, input int unsigned idx_w);
    return (addr >> (idx_w + 32'd2)) != 32'd0;
  endfunction

endpackage

// File: rtl/rvga_mem_responder_sram.sv
// rvga_sram: single-port word array with synchronous write and registered read.
// Contents have no reset; the read register keeps its value during a write cycle.
module rvga_sram
  import rvga_types::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o
);

  rvga_word r_mem [DEPTH];
  rvga_word r_rdata;

  // One access per cycle: write when enabled, otherwise refresh the read register
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[addr_i] <= wdata_i;
    end else begin
      r_rdata <= r_mem[addr_i];
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/rvga_mem_responder.sv
// rvga_mem_responder: fixed-latency instruction/data memory model for a RISC-V core.
// Optional macro RVGA_MEM_BOUNDS_CHECK_EN: out-of-range accesses return the error word and set err_o.
module rvga_mem_responder
  import rvga_types::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] imem_addr_i,
  output logic [31:0] imem_data_o,
  output logic        imem_resp_v_o,
  input  logic        dmem_r_v_i,
  input  logic        dmem_w_v_i,
  input  logic [31:0] dmem_addr_i,
  input  logic [31:0] dmem_data_i,
  output logic [31:0] dmem_data_o,
  output logic        dmem_resp_v_o,
  output logic        err_o
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  rvga_mem_state r_state;
  logic [3:0]    r_cnt;
  rvga_word      r_addr;
  rvga_word      r_wdata;
  logic          r_wr;
  logic          r_imem_v;
  logic          r_dmem_v;
  rvga_word      r_imem_data;
  rvga_word      r_dmem_data;

  logic             w_dmem_req;
  logic             w_last;
  logic             w_redirect;
  logic             w_oob;
  logic             w_we;
  logic [IDX_W-1:0] w_idx;
  rvga_word         w_rdata;
  rvga_word         w_resp_data;

  assign w_dmem_req = dmem_r_v_i | dmem_w_v_i;
  assign w_last     = (r_state != IDLE) && (r_cnt == 4'd0);
  assign w_redirect = (r_state == IMEM) && (imem_addr_i != r_addr);
  assign w_we       = (r_state == DMEM) && w_last && r_wr && !w_oob && !rst_i;

  // The array reads every cycle; in IDLE it follows the request about to be
  // accepted so a LATENCY of 1 still sees the right word on its last cycle.
  always_comb begin
    w_idx = r_addr[IDX_W+1:2];
    if (r_state == IDLE) begin
      if (w_dmem_req) begin
        w_idx = dmem_addr_i[IDX_W+1:2];
      end else begin
        w_idx = imem_addr_i[IDX_W+1:2];
      end
    end else begin
      w_idx = r_addr[IDX_W+1:2];
    end
  end

  // Response word for the access completing this cycle
  always_comb begin
    w_resp_data = w_rdata;
    if (w_oob) begin
      w_resp_data = RVGA_MEM_ERR_WORD;
    end else if (r_wr) begin
      w_resp_data = r_wdata;
    end else begin
      w_resp_data = w_rdata;
    end
  end

  rvga_sram #(
    .DEPTH(DEPTH)
  ) u_sram (
    .clk_i  (clk_i),
    .we_i   (w_we),
    .addr_i (w_idx),
    .wdata_i(r_wdata),
    .rdata_o(w_rdata)
  );

  // Request arbitration, latency countdown and registered responses
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wr        <= 1'b0;
      r_imem_v    <= 1'b0;
      r_dmem_v    <= 1'b0;
      r_imem_data <= 32'd0;
      r_dmem_data <= 32'd0;
    end else begin
      r_imem_v <= 1'b0;
      r_dmem_v <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= CNT_LOAD;
          if (w_dmem_req) begin
            r_state <= DMEM;
            r_addr  <= dmem_addr_i;
            r_wdata <= dmem_data_i;
            r_wr    <= dmem_w_v_i;
          end else begin
            r_state <= IMEM;
            r_addr  <= imem_addr_i;
            r_wr    <= 1'b0;
          end
        end
        IMEM: begin
          // A redirect drops the fetch silently; the new address is taken from IDLE
          if (w_redirect) begin
            r_state <= IDLE;
          end else if (w_last) begin
            r_state     <= IDLE;
            r_imem_v    <= 1'b1;
            r_imem_data <= w_resp_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DMEM: begin
          if (w_last) begin
            r_state     <= IDLE;
            r_dmem_v    <= 1'b1;
            r_dmem_data <= w_resp_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef RVGA_MEM_BOUNDS_CHECK_EN
  logic r_err;

  assign w_oob = rvga_addr_oob(r_addr, IDX_W);

  // Sticky out-of-range flag, raised when an error word is returned
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (w_last && !w_redirect && w_oob) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign err_o = r_err;
`else
  assign w_oob = 1'b0;
  assign err_o = 1'b0;
`endif

  assign imem_data_o   = r_imem_data;
  assign imem_resp_v_o = r_imem_v;
  assign dmem_data_o   = r_dmem_data;
  assign dmem_resp_v_o = r_dmem_v;

endmodule

// File: tb/tb_rvga_mem_responder.sv
// Randomized scoreboard bench for rvga_mem_responder against a transaction-level memory model.
module tb_rvga_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] imem_addr_i;
  logic [31:0] imem_data_o;
  logic        imem_resp_v_o;
  logic        dmem_r_v_i;
  logic        dmem_w_v_i;
  logic [31:0] dmem_addr_i;
  logic [31:0] dmem_data_i;
  logic [31:0] dmem_data_o;
  logic        dmem_resp_v_o;
  logic        err_o;

  always #5 clk = ~clk;

  rvga_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_addr_i  (imem_addr_i),
    .imem_data_o  (imem_data_o),
    .imem_resp_v_o(imem_resp_v_o),
    .dmem_r_v_i   (dmem_r_v_i),
    .dmem_w_v_i   (dmem_w_v_i),
    .dmem_addr_i  (dmem_addr_i),
    .dmem_data_i  (dmem_data_i),
    .dmem_data_o  (dmem_data_o),
    .dmem_resp_v_o(dmem_resp_v_o),
    .err_o        (err_o)
  );

  typedef struct {
    bit          is_d;
    int          edge_no;
    logic [31:0] data;
    bit          known;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  // Reference model: memory image plus the one transaction in flight
  logic [31:0] mm [DEPTH];
  bit          mk [DEPTH];
  bit          m_busy = 1'b0;
  bit          m_kind_d, m_wr, m_d_done, m_i_acc;
  logic [31:0] m_addr, m_wdata;
  int          m_done_edge;
  logic [31:0] m_idata = 32'd0, m_ddata = 32'd0;
  bit          m_iknown = 1'b0, m_dknown = 1'b0, m_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, req, cyc);
    end
  endtask

  function automatic bit addr_oob(input logic [31:0] a);
`ifdef RVGA_MEM_BOUNDS_CHECK_EN
    return a >= 32'(4 * DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  // Predict the effect of the coming rising edge from the inputs now applied
  task automatic model_step();
    int          e;
    int          idx;
    bit          oob;
    logic [31:0] d;
    bit          k;
    exp_t        x;
    e = cyc + 1;
    m_d_done = 1'b0;
    m_i_acc  = 1'b0;
    if (rst_i) begin
      m_busy = 1'b0; m_idata = 32'd0; m_ddata = 32'd0;
      m_iknown = 1'b1; m_dknown = 1'b1; m_err = 1'b0;
    end else if (!m_busy) begin
      m_busy = 1'b1;
      m_done_edge = e + LAT;
      if (dmem_r_v_i || dmem_w_v_i) begin
        m_kind_d = 1'b1; m_wr = dmem_w_v_i; m_addr = dmem_addr_i; m_wdata = dmem_data_i;
      end else begin
        m_kind_d = 1'b0; m_wr = 1'b0; m_addr = imem_addr_i; m_i_acc = 1'b1;
      end
    end else if (!m_kind_d && imem_addr_i != m_addr) begin
      m_busy = 1'b0;
    end else if (e == m_done_edge) begin
      idx = int'((m_addr / 32'd4) % 32'(DEPTH));
      oob = addr_oob(m_addr);
      if (oob) begin
        d = 32'hDEADBEEF; k = 1'b1; m_err = 1'b1;
      end else if (m_kind_d && m_wr) begin
        d = m_wdata; k = 1'b1; mm[idx] = m_wdata; mk[idx] = 1'b1;
      end else begin
        d = mm[idx]; k = mk[idx];
      end
      if (m_kind_d) begin
        m_ddata = d; m_dknown = k; m_d_done = 1'b1;
      end else begin
        m_idata = d; m_iknown = k;
      end
      x.is_d = m_kind_d; x.edge_no = e; x.data = d; x.known = k;
      sbq.push_back(x);
      m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic dop(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    int t;
    t = 0;
    dmem_r_v_i = r; dmem_w_v_i = w; dmem_addr_i = a; dmem_data_i = d;
    do begin
      tick();
      t++;
    end while (!m_d_done && t < 40);
    check("dmem_op_done", {31'd0, m_d_done}, 32'd1);
    dmem_r_v_i = 1'b0; dmem_w_v_i = 1'b0;
  endtask

  task automatic random_phase();
    int unsigned sel;
    logic [31:0] a;
    for (int n = 0; n < 150; n++) begin
      sel = $urandom_range(0, 9);
      a = {24'd0, 8'($urandom_range(0, 255))};
      if ($urandom_range(0, 9) == 0) a = a | 32'h0001_0000;
      if (sel < 3) dop(1'b1, 1'b0, a, 32'd0);
      else if (sel < 6) dop(1'b0, 1'b1, a, $urandom);
      else if (sel == 6) dop(1'b1, 1'b1, a, $urandom);
      else if (sel == 7) begin
        imem_addr_i = a;
        idle($urandom_range(1, 4));
      end else if (sel == 8) begin
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
      end else idle($urandom_range(1, 3));
    end
  endtask

  // Monitor: checks every cycle a little after the rising edge
  initial begin
    exp_t x;
    bit   eiv, edv;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        eiv = 1'b0; edv = 1'b0;
        if (sbq.size() > 0 && sbq[0].edge_no <= cyc) begin
          eiv = !sbq[0].is_d;
          edv = sbq[0].is_d;
        end
        check("imem_resp_v", {31'd0, imem_resp_v_o}, {31'd0, eiv});
        check("dmem_resp_v", {31'd0, dmem_resp_v_o}, {31'd0, edv});
        check("resp_exclusive", {31'd0, imem_resp_v_o & dmem_resp_v_o}, 32'd0);
        if (eiv || edv) begin
          x = sbq.pop_front();
          if (x.known && x.is_d && dmem_resp_v_o) check("dmem_resp_data", dmem_data_o, x.data);
          if (x.known && !x.is_d && imem_resp_v_o) check("imem_resp_data", imem_data_o, x.data);
        end
        if (m_iknown) check("imem_data_hold", imem_data_o, m_idata);
        if (m_dknown) check("dmem_data_hold", dmem_data_o, m_ddata);
        check("err", {31'd0, err_o}, {31'd0, m_err});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    int t;
    rst_i = 1'b1; imem_addr_i = 32'h10;
    dmem_r_v_i = 1'b0; dmem_w_v_i = 1'b0; dmem_addr_i = 32'd0; dmem_data_i = 32'd0;
    for (int i = 0; i < DEPTH; i++) mk[i] = 1'b0;
    @(negedge clk);
    tick();
    mon_en = 1'b1;
    idle(2);
    rst_i = 1'b0;

    // Preload the low 64 words, including the fetch target at 0x10
    for (int i = 0; i < 64; i++) begin
      dop(1'b0, 1'b1, 32'(i * 4), (i == 4) ? 32'h00500093 : $urandom);
    end

    imem_addr_i = 32'h10;
    idle(12);

    dop(1'b0, 1'b1, 32'h40, 32'hCAFEF00D);
    dop(1'b1, 1'b0, 32'h40, 32'd0);
    dop(1'b1, 1'b1, 32'h48, 32'h1234_5678);
    dop(1'b1, 1'b0, 32'h4B, 32'd0);

    // Data read raised while the responder is idle with a fetch pending
    t = 0;
    while (m_busy && t < 10) begin tick(); t++; end
    dop(1'b1, 1'b0, 32'h10, 32'd0);
    idle(6);

    // Fetch redirect one cycle after acceptance
    t = 0;
    do begin tick(); t++; end while (!m_i_acc && t < 10);
    imem_addr_i = 32'h80;
    idle(10);
    imem_addr_i = 32'h10;

    // Reset during an in-flight write to 0x44
    dmem_w_v_i = 1'b1; dmem_addr_i = 32'h44; dmem_data_i = 32'hBAD0_0044;
    t = 0;
    do begin tick(); t++; end while (!(m_busy && m_kind_d) && t < 10);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; dmem_w_v_i = 1'b0;
    idle(2);
    dop(1'b1, 1'b0, 32'h44, 32'd0);

    // Address above the array range
    dop(1'b1, 1'b0, 32'h0001_0000, 32'd0);
    idle(3);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;

    random_phase();

    imem_addr_i = 32'h10;
    idle(6);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rvga_mem_responder.md
RVGA_MEM_RESPONDER -- requirements
Module: rvga_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024; backing-array depth in 32-bit words, power of two.
REQ-002 SHALL have parameter LATENCY, default 2; cycles from request acceptance to response, legal range 1..15.
REQ-003 SHALL have port clk_i  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_addr_i  in  32 (rvga_word)  instruction fetch byte address; request is implicitly always valid.
REQ-006 SHALL have port imem_data_o  out  32 (rvga_word)  fetched instruction word.
REQ-007 SHALL have port imem_resp_v_o  out  1  one-cycle pulse, imem_data_o valid.
REQ-008 SHALL have port dmem_r_v_i  in  1  data read request, level, held until response.
REQ-009 SHALL have port dmem_w_v_i  in  1  data write request, level, held until response.
REQ-010 SHALL have port dmem_addr_i  in  32 (rvga_word)  data byte address.
REQ-011 SHALL have port dmem_data_i  in  32 (rvga_word)  write data.
REQ-012 SHALL have port dmem_data_o  out  32 (rvga_word)  read data.
REQ-013 SHALL have port dmem_resp_v_o  out  1  one-cycle pulse, data access complete.
REQ-014 SHALL have port err_o  out  1  sticky out-of-range flag (see Configuration).

Function
REQ-015 SHALL implement FSM states IDLE, IMEM, DMEM.
REQ-016 In IDLE, with dmem_r_v_i or dmem_w_v_i high: SHALL capture dmem address, data and op, and enter DMEM; dmem takes priority over imem.
REQ-017 In IDLE, with no dmem request: SHALL capture imem_addr_i and enter IMEM.
REQ-018 On entry to IMEM or DMEM, SHALL load the latency counter to LATENCY-1; SHALL decrement it each busy cycle.
REQ-019 When the counter is 0: SHALL perform the array access, pulse the matching resp_v for exactly one cycle, and return to IDLE; acceptance at edge t yields resp_v high in cycle t+LATENCY.
REQ-020 Word index SHALL be addr[$clog2(DEPTH)+1:2]; addr[1:0] ignored; full-word writes only.
REQ-021 With dmem_r_v_i and dmem_w_v_i both high: SHALL perform the write, and dmem_data_o SHALL return the written word.
REQ-022 Write response: dmem_data_o SHALL return dmem_data_i as captured.
REQ-023 In IMEM, if imem_addr_i differs from the captured address (branch redirect): SHALL abort without a response and return to IDLE; the new address is accepted the following cycle.
REQ-024 A DMEM operation SHALL NOT be aborted; a write commits even if the request drops early.
REQ-025 imem_data_o and dmem_data_o SHALL be registered and hold their value until the next response on the same port.
REQ-026 imem_resp_v_o and dmem_resp_v_o SHALL never be high in the same cycle.

Reset
REQ-027 While rst_i is high at an edge: FSM SHALL go to IDLE, counter to 0, both resp_v to 0, both data outputs to 0, and err_o to 0.
REQ-028 Reset mid-operation SHALL discard the in-flight request: no response, no array write.
REQ-029 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-030 Macro RVGA_MEM_BOUNDS_CHECK_EN defined: any address with bits above the index range nonzero SHALL return 32'hDEADBEEF, suppress the write, still respond, and set err_o until reset.
REQ-031 Macro RVGA_MEM_BOUNDS_CHECK_EN undefined: addresses SHALL wrap modulo DEPTH, and err_o SHALL be tied 0.

Structure
REQ-032 The rvga_types package SHALL hold the rvga_mem_state enum (IDLE/IMEM/DMEM) and the constant RVGA_MEM_ERR_WORD = 32'hDEADBEEF.
REQ-033 The backing array SHALL be a sub-module, rvga_sram: single-port, synchronous read/write, parameter DEPTH.

Verification
REQ-034 LATENCY=2, imem_addr_i=0x10 held, mem[4]=0x00500093: imem_resp_v_o high exactly 2 cycles after acceptance with imem_data_o=0x00500093, then repeats every 3 cycles.
REQ-035 dmem_w_v_i=1, addr=0x40, data=0xCAFEF00D, then dmem_r_v_i=1 at addr 0x40: both dmem_resp_v_o pulses occur after 2 cycles, and the read returns 0xCAFEF00D.
REQ-036 dmem read and imem address both pending in IDLE: dmem served first; imem response follows, never in the same cycle.
REQ-037 imem_addr_i changes 0x10->0x80 one cycle after acceptance: no response for 0x10; response for 0x80 data arrives LATENCY cycles after re-acceptance.
REQ-038 rst_i asserted during DMEM write to 0x44: no dmem_resp_v_o; subsequent read of 0x44 returns the old value; all outputs 0 after reset.
REQ-039 With the macro defined, read of 0x0001_0000 (DEPTH=1024): dmem_data_o=0xDEADBEEF and err_o=1 sticky. Without the macro, the same read returns mem[0].
